// File: rtl/p18_score_pkg.sv
// Shared types and constants for the score painter: FSM states, cell geometry,
// the per-pixel glyph selection record and the 3x5 digit font.
package p18_score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SAT  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned CELL_W           = 8;
  localparam int unsigned CELL_H           = 10;
  localparam int unsigned GLYPH_SCALE_LOG2 = 1;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Which glyph pixel the current raster position maps to, if any.
  typedef struct packed {
    logic               valid;
    logic [DIGIT_W-1:0] digit;
    logic [1:0]         col;
    logic [2:0]         row;
  } glyph_sel_t;

  // Rows top to bottom, each row's leftmost column in its MSB.
  function automatic logic [14:0] font_glyph(input logic [DIGIT_W-1:0] d);
    logic [14:0] g;
    case (d)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b010_110_010_010_111;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = 15'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/p18_score_painter_font.sv
// p18_digit_font: combinational 3x5 digit ROM lookup; non-BCD digits stay dark.
module p18_digit_font
  import p18_score_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [1:0]         col,
  input  logic [2:0]         row,
  output logic               pixel
);

  logic [14:0] glyph;
  int          bit_idx;

  always_comb begin
    glyph   = font_glyph(digit);
    bit_idx = 14 - (int'(row) * 3 + int'(col));
    pixel   = 1'b0;
    if (col < 2'd3 && row < 3'd5) pixel = glyph[bit_idx];
  end

endmodule

// File: rtl/p18_score_painter.sv
// p18_score_painter: BCD score keeper fed by block collisions, painted as a video-mux layer.
// Optional high-score register and second digit row when P18_SCORE_HIGHSCORE_EN is defined.
module p18_score_painter
  import p18_score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned POINTS_PER_BLOCK = 1,
  parameter logic [9:0]  SCORE_X          = 10'd560,
  parameter logic [8:0]  SCORE_Y          = 9'd12,
  parameter logic [5:0]  SCORE_COLOR      = 6'b111111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    hpos,
  input  logic [8:0]                    vpos,
  input  logic                          display_active,
  input  logic                          frame_pulse,
  input  logic                          block_collision,
  input  logic                          reset_score,
  output logic                          in_score,
  output logic [5:0]                    color,
  output logic [DIGIT_W*NUM_DIGITS-1:0] score_bcd,
  output logic                          score_overflow
`ifdef P18_SCORE_HIGHSCORE_EN
  ,
  output logic [DIGIT_W*NUM_DIGITS-1:0] hiscore_bcd
`endif
);

  localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CELL_SHIFT = $clog2(CELL_W);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [9:0]       ROW_W_PX   = 10'(NUM_DIGITS * CELL_W);
  localparam logic [2:0]       GLYPH_W_PX = 3'(3 << GLYPH_SCALE_LOG2);
  localparam logic [8:0]       HI_ROW_Y   = 9'(SCORE_Y + 9'd12);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] carry;
  logic               hit_pending;
  logic [BCD_W-1:0]   disp_bcd;

  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] add_digit;
  logic [DIGIT_W:0]   add_sum;
  logic               add_wrap;

  // One-digit BCD adder for the digit currently addressed by the FSM.
  always_comb begin
    cur_digit = score_bcd[idx*DIGIT_W +: DIGIT_W];
    add_sum   = {1'b0, cur_digit} + {1'b0, carry};
    add_wrap  = add_sum > {1'b0, BCD_MAX};
    add_digit = add_wrap ? DIGIT_W'(add_sum - (DIGIT_W+1)'(10)) : add_sum[DIGIT_W-1:0];
  end

`ifdef P18_SCORE_HIGHSCORE_EN
  logic score_gt_hi;

  // Magnitude compare, the first differing digit from the MSD decides.
  always_comb begin
    logic decided;
    int   j;
    score_gt_hi = 1'b0;
    decided     = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      j = int'(NUM_DIGITS) - 1 - i;
      if (!decided && score_bcd[j*DIGIT_W +: DIGIT_W] != hiscore_bcd[j*DIGIT_W +: DIGIT_W]) begin
        decided     = 1'b1;
        score_gt_hi = score_bcd[j*DIGIT_W +: DIGIT_W] > hiscore_bcd[j*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hiscore_bcd <= '0;
    else if (reset_score && score_gt_hi) hiscore_bcd <= score_bcd;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      carry          <= '0;
      hit_pending    <= 1'b0;
      score_bcd      <= '0;
      disp_bcd       <= '0;
      score_overflow <= 1'b0;
    end else if (reset_score) begin
      state          <= IDLE;
      idx            <= '0;
      carry          <= '0;
      hit_pending    <= 1'b0;
      score_bcd      <= '0;
      disp_bcd       <= '0;
      score_overflow <= 1'b0;
    end else begin
      if (frame_pulse) disp_bcd <= score_bcd;
      if (block_collision) hit_pending <= 1'b1;
      case (state)
        IDLE: begin
          // A saturated score consumes the hit without touching the digits.
          if (frame_pulse && (hit_pending || block_collision)) begin
            hit_pending <= 1'b0;
            if (!score_overflow) begin
              state <= ADD;
              idx   <= '0;
              carry <= DIGIT_W'(POINTS_PER_BLOCK);
            end
          end
        end
        ADD: begin
          score_bcd[idx*DIGIT_W +: DIGIT_W] <= add_digit;
          carry <= add_wrap ? DIGIT_W'(1) : DIGIT_W'(0);
          if (!add_wrap)             state <= IDLE;
          else if (idx == LAST_IDX)  state <= SAT;
          else                       idx   <= idx + IDX_W'(1);
        end
        SAT: begin
          score_bcd      <= {NUM_DIGITS{BCD_MAX}};
          score_overflow <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Maps the raster position onto a digit row starting at row_top.
  function automatic glyph_sel_t cell_select(input logic [9:0] x, input logic [8:0] y,
                                             input logic [8:0] row_top,
                                             input logic [BCD_W-1:0] bcd);
    glyph_sel_t         sel;
    logic [9:0]         rel_x;
    logic [8:0]         rel_y;
    logic [2:0]         cx;
    logic [DIGIT_W-1:0] d;
    logic               lead_seen;
    logic               lit_ok;
    sel       = '0;
    rel_x     = x - SCORE_X;
    rel_y     = y - row_top;
    cx        = 3'(rel_x);
    lead_seen = 1'b0;
    lit_ok    = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      d = bcd[(int'(NUM_DIGITS) - 1 - k)*DIGIT_W +: DIGIT_W];
      if (d != '0 || k == int'(NUM_DIGITS) - 1) lead_seen = 1'b1;
      if ((rel_x >> CELL_SHIFT) == 10'(k)) begin
        sel.digit = d;
        lit_ok    = lead_seen;
      end
    end
    sel.valid = lit_ok && (x >= SCORE_X) && (rel_x < ROW_W_PX) && (cx < GLYPH_W_PX) &&
                (y >= row_top) && (rel_y < 9'(CELL_H));
    sel.col   = 2'(cx >> GLYPH_SCALE_LOG2);
    sel.row   = 3'(rel_y >> GLYPH_SCALE_LOG2);
    return sel;
  endfunction

  glyph_sel_t sel_score;
  logic       px_score;
  logic       lit;

  assign sel_score = cell_select(hpos, vpos, SCORE_Y, disp_bcd);

  p18_digit_font u_font_score (
    .digit (sel_score.digit),
    .col   (sel_score.col),
    .row   (sel_score.row),
    .pixel (px_score)
  );

`ifdef P18_SCORE_HIGHSCORE_EN
  glyph_sel_t sel_hi;
  logic       px_hi;

  assign sel_hi = cell_select(hpos, vpos, HI_ROW_Y, hiscore_bcd);

  p18_digit_font u_font_hi (
    .digit (sel_hi.digit),
    .col   (sel_hi.col),
    .row   (sel_hi.row),
    .pixel (px_hi)
  );

  assign lit = (sel_score.valid & px_score) | (sel_hi.valid & px_hi);
`else
  assign lit = sel_score.valid & px_score;
`endif

  always_comb begin
    in_score = display_active & lit;
    color    = in_score ? SCORE_COLOR : 6'b0;
  end

endmodule
